// File: rtl/ring_cadence_ctrl.sv
// ring_cadence_ctrl: ring-tone cadence sequencer for the answering machine.
// Gates the beeper (via beep_en -> beeper rst_n) with ON_MS bursts and OFF_MS
// silences. After MAX_RINGS unanswered rings it pulses answer.
// Pickup and caller hang-up are reported as one-cycle pulses.
// Optional feature macro: RING_MISSED_LOG_EN adds a saturating missed-call
// counter on missed_cnt. When the macro is undefined, missed_cnt is tied to 0.
module ring_cadence_ctrl #(
    parameter int TICK_DIV  = 100000,
    parameter int ON_MS     = 1000,
    parameter int OFF_MS    = 2000,
    parameter int MAX_RINGS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ring_req,
    input  logic       off_hook,
    output logic       beep_en,
    output logic       busy,
    output logic [3:0] ring_cnt,
    output logic       answer,
    output logic       picked_up,
    output logic       missed,
    output logic [7:0] missed_cnt
);

    typedef enum logic [1:0] {IDLE, RING_ON, RING_OFF, ANSWER} state_t;

    localparam logic [16:0] TICK_LAST = 17'(TICK_DIV - 1);
    localparam logic [15:0] ON_LAST   = 16'(ON_MS - 1);
    localparam logic [15:0] OFF_LAST  = 16'(OFF_MS - 1);
    localparam logic [3:0]  RING_LAST = 4'(MAX_RINGS);

    state_t      state;
    logic [16:0] tick_cnt;
    logic [15:0] ms_cnt;
    logic        req_prev;

    logic ringing;
    logic tick;
    logic expire;
    logic pickup_evt;
    logic miss_evt;

    // Phase timing and abort conditions; pickup outranks hang-up.
    assign ringing    = (state == RING_ON) || (state == RING_OFF);
    assign tick       = (tick_cnt == TICK_LAST);
    assign expire     = tick && (ms_cnt == ((state == RING_ON) ? ON_LAST : OFF_LAST));
    assign pickup_evt = ringing && off_hook;
    assign miss_evt   = ringing && !off_hook && !ring_req;

    // Cadence FSM with registered outputs; timers restart on every state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            ms_cnt    <= '0;
            req_prev  <= 1'b0;
            ring_cnt  <= '0;
            beep_en   <= 1'b0;
            busy      <= 1'b0;
            answer    <= 1'b0;
            picked_up <= 1'b0;
            missed    <= 1'b0;
        end else begin
            req_prev  <= ring_req;
            answer    <= 1'b0;
            picked_up <= 1'b0;
            missed    <= 1'b0;
            case (state)
                IDLE: begin
                    if (ring_req && !req_prev && !off_hook) begin
                        state    <= RING_ON;
                        ring_cnt <= 4'd1;
                        beep_en  <= 1'b1;
                        busy     <= 1'b1;
                        tick_cnt <= '0;
                        ms_cnt   <= '0;
                    end
                end
                RING_ON, RING_OFF: begin
                    if (pickup_evt || miss_evt) begin
                        state     <= IDLE;
                        ring_cnt  <= '0;
                        beep_en   <= 1'b0;
                        busy      <= 1'b0;
                        tick_cnt  <= '0;
                        ms_cnt    <= '0;
                        picked_up <= pickup_evt;
                        missed    <= miss_evt;
                    end else if (expire) begin
                        tick_cnt <= '0;
                        ms_cnt   <= '0;
                        if (state == RING_OFF) begin
                            state    <= RING_ON;
                            beep_en  <= 1'b1;
                            ring_cnt <= ring_cnt + 4'd1;
                        end else if (ring_cnt == RING_LAST) begin
                            state   <= ANSWER;
                            answer  <= 1'b1;
                            beep_en <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            state   <= RING_OFF;
                            beep_en <= 1'b0;
                        end
                    end else if (tick) begin
                        tick_cnt <= '0;
                        ms_cnt   <= ms_cnt + 16'd1;
                    end else begin
                        tick_cnt <= tick_cnt + 17'd1;
                    end
                end
                ANSWER: begin
                    state    <= IDLE;
                    ring_cnt <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RING_MISSED_LOG_EN
    // Missed-call log: counts hang-ups during ringing, saturates, cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            missed_cnt <= '0;
        end else if (miss_evt && (missed_cnt != 8'hFF)) begin
            missed_cnt <= missed_cnt + 8'd1;
        end
    end
`else
    assign missed_cnt = 8'd0;
`endif

endmodule
